// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, state/class encodings, writeback selects and fault codes for the sequencer
package core_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM_CHECK, S_MEM, S_WRITEBACK, S_FAULT
   } state_t;
   typedef enum logic [3:0] {
      CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
   } cls_t;
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_KEY     = 2'd1;
   localparam logic [1:0] FC_TIMEOUT = 2'd2;
   localparam logic [1:0] FC_ILLEGAL = 2'd3;
   typedef struct packed {
      logic       fetch_req;
      logic       ir_we;
      logic       alu_en;
      logic       mem_req;
      logic       mem_we;
      logic       reg_we;
      logic [1:0] wb_sel;
      logic       pc_we;
      logic       branch_taken;
      logic       retired;
   } strobe_t;
endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: datapath/memory/security handshake between the sequencer and the rest of the core
interface core_sequencer_if;
   logic [6:0] opcode;
   logic       alu_zero;
   logic       key_ok;
   logic       mem_ready;
   logic       fetch_req;
   logic       ir_we;
   logic       alu_en;
   logic       mem_req;
   logic       mem_we;
   logic       reg_we;
   logic [1:0] wb_sel;
   logic       pc_we;
   logic       branch_taken;
   logic       retired;
   logic       fault;
   logic [1:0] fault_code;
   logic [2:0] state;
   modport master (
      input  opcode, alu_zero, key_ok, mem_ready,
      output fetch_req, ir_we, alu_en, mem_req, mem_we, reg_we, wb_sel, pc_we,
             branch_taken, retired, fault, fault_code, state
   );
   modport slave (
      output opcode, alu_zero, key_ok, mem_ready,
      input  fetch_req, ir_we, alu_en, mem_req, mem_we, reg_we, wb_sel, pc_we,
             branch_taken, retired, fault, fault_code, state
   );
endinterface

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps a 7-bit RV32I major opcode to an instruction class plus an illegal flag
module opcode_classifier
   import core_pkg::*;
(
   input  logic [6:0] opcode,
   output cls_t       cls,
   output logic       illegal
);
   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OP_R:      cls = CL_R;
         OP_IMM:    cls = CL_IMM;
         OP_LOAD:   cls = CL_LOAD;
         OP_STORE:  cls = CL_STORE;
         OP_BRANCH: cls = CL_BRANCH;
         OP_JAL:    cls = CL_JAL;
         OP_JALR:   cls = CL_JALR;
         OP_LUI:    cls = CL_LUI;
         OP_AUIPC:  cls = CL_AUIPC;
         default: begin
            cls     = CL_R;
            illegal = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/key-checked mem/writeback control with sticky fault
module core_sequencer
   import core_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input logic             clk,
   input logic             reset,
   core_sequencer_if.master bus
);
   state_t     st, nxt;
   cls_t       cls, cls_live;
   logic       illegal, waiting, expired, jump;
   logic [3:0] cnt;
   logic [1:0] code;
   strobe_t    s;
   opcode_classifier u_classifier (.opcode(bus.opcode), .cls(cls_live), .illegal(illegal));
   assign waiting = (st == S_FETCH || st == S_MEM) && !bus.mem_ready;
   // ready in the cycle the count would hit WAIT_MAX wins, since waiting is false then
   assign expired = waiting && cnt == 4'(WAIT_MAX - 1);
   assign jump    = cls == CL_JAL || cls == CL_JALR;
   always_comb begin
      s   = '0;
      nxt = st;
      case (st)
         S_FETCH: begin
            s.fetch_req = 1'b1;
            s.ir_we     = bus.mem_ready;
            nxt         = bus.mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
         end
         S_DECODE: nxt = illegal ? S_FAULT : S_EXECUTE;
         S_EXECUTE: begin
            s.alu_en       = 1'b1;
            s.pc_we        = cls == CL_BRANCH;
            s.retired      = cls == CL_BRANCH;
            s.branch_taken = cls == CL_BRANCH && bus.alu_zero;
            nxt            = cls == CL_BRANCH ? S_FETCH
                           : (cls == CL_LOAD || cls == CL_STORE) ? S_MEM_CHECK : S_WRITEBACK;
         end
         S_MEM_CHECK: nxt = bus.key_ok ? S_MEM : S_FAULT;
         S_MEM: begin
            s.mem_req = 1'b1;
            s.mem_we  = cls == CL_STORE;
            s.pc_we   = bus.mem_ready && cls == CL_STORE;
            s.retired = bus.mem_ready && cls == CL_STORE;
            nxt       = !bus.mem_ready ? (expired ? S_FAULT : S_MEM)
                      : cls == CL_STORE ? S_FETCH : S_WRITEBACK;
         end
         S_WRITEBACK: begin
            s.reg_we       = 1'b1;
            s.pc_we        = 1'b1;
            s.retired      = 1'b1;
            s.branch_taken = jump;
            s.wb_sel       = cls == CL_LOAD ? WB_MEM : jump ? WB_PC4 : WB_ALU;
            nxt            = S_FETCH;
         end
         default: nxt = S_FAULT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st   <= S_FETCH;
         cls  <= CL_R;
         cnt  <= '0;
         code <= FC_NONE;
      end else begin
         st <= nxt;
         if (st == S_DECODE) cls <= cls_live;
         if (nxt == S_FAULT && st != S_FAULT)
            code <= st == S_DECODE ? FC_ILLEGAL : st == S_MEM_CHECK ? FC_KEY : FC_TIMEOUT;
         cnt <= nxt != st ? 4'd0 : waiting ? cnt + 4'd1 : cnt;
      end
   end
   assign {bus.fetch_req, bus.ir_we, bus.alu_en, bus.mem_req, bus.mem_we, bus.reg_we,
           bus.wb_sel, bus.pc_we, bus.branch_taken, bus.retired} = reset ? '0 : s;
   assign bus.fault      = !reset && st == S_FAULT;
   assign bus.fault_code = reset ? FC_NONE : code;
   assign bus.state      = reset ? 3'd0 : st;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed per-cycle checks of state and strobes against hand-computed vectors
module tb_core_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] sb_obs;
   core_sequencer_if bus ();
   core_sequencer #(.WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // fetch_req ir_we alu_en mem_req mem_we reg_we wb_sel[1:0] pc_we branch_taken retired
   assign sb_obs = {bus.fetch_req, bus.ir_we, bus.alu_en, bus.mem_req, bus.mem_we, bus.reg_we,
                    bus.wb_sel, bus.pc_we, bus.branch_taken, bus.retired};
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] sb, input logic rdy);
      bus.mem_ready = rdy;
      #1;
      chk({tag, " state"}, 32'(bus.state), 32'(st));
      chk({tag, " strobes"}, 32'(sb_obs), 32'(sb));
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask
   initial begin
      bus.opcode    = 7'b0110011;
      bus.alu_zero  = 1'b0;
      bus.key_ok    = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state", 32'(bus.state), 32'd0);
      chk("reset strobes", 32'(sb_obs), 32'd0);
      chk("reset fault", 32'(bus.fault), 32'd0);
      chk("reset code", 32'(bus.fault_code), 32'd0);
      reset = 1'b0;
      cyc("r fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("r decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("r exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("r wb", 3'd5, 11'b00000100101, 1'b0);
      bus.opcode = 7'b0000011;
      bus.key_ok = 1'b1;
      cyc("ld fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("ld decode", 3'd1, 11'b00000000000, 1'b0);
      bus.opcode = 7'b1111111;
      cyc("ld exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("ld check", 3'd3, 11'b00000000000, 1'b0);
      for (int i = 0; i < 3; i++) cyc("ld mem wait", 3'd4, 11'b00010000000, 1'b0);
      cyc("ld mem ready", 3'd4, 11'b00010000000, 1'b1);
      cyc("ld wb", 3'd5, 11'b00000101101, 1'b0);
      bus.opcode = 7'b0100011;
      cyc("st fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("st decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("st exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("st check", 3'd3, 11'b00000000000, 1'b0);
      cyc("st mem", 3'd4, 11'b00011000101, 1'b1);
      bus.opcode = 7'b1101111;
      cyc("jal fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("jal decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("jal exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("jal wb", 3'd5, 11'b00000110111, 1'b0);
      bus.opcode   = 7'b1100011;
      bus.alu_zero = 1'b1;
      cyc("br1 fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("br1 decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("br1 exec", 3'd2, 11'b00100000111, 1'b0);
      bus.alu_zero = 1'b0;
      cyc("br0 fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("br0 decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("br0 exec", 3'd2, 11'b00100000101, 1'b0);
      bus.opcode = 7'b0100011;
      bus.key_ok = 1'b0;
      cyc("deny fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("deny decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("deny exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("deny check", 3'd3, 11'b00000000000, 1'b0);
      for (int i = 0; i < 20; i++) cyc("deny hold", 3'd6, 11'b00000000000, 1'(i & 1));
      chk("deny fault", 32'(bus.fault), 32'd1);
      chk("deny code", 32'(bus.fault_code), 32'd1);
      pulse_reset();
      #1;
      chk("clear state", 32'(bus.state), 32'd0);
      chk("clear fault", 32'(bus.fault), 32'd0);
      chk("clear code", 32'(bus.fault_code), 32'd0);
      for (int i = 0; i < 15; i++) cyc("to wait", 3'd0, 11'b10000000000, 1'b0);
      cyc("to fault", 3'd6, 11'b00000000000, 1'b0);
      chk("to fault flag", 32'(bus.fault), 32'd1);
      chk("to code", 32'(bus.fault_code), 32'd2);
      pulse_reset();
      bus.opcode = 7'b1111111;
      for (int i = 0; i < 14; i++) cyc("edge wait", 3'd0, 11'b10000000000, 1'b0);
      cyc("edge ready", 3'd0, 11'b11000000000, 1'b1);
      chk("edge no fault", 32'(bus.fault), 32'd0);
      cyc("ill decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("ill fault", 3'd6, 11'b00000000000, 1'b0);
      chk("ill code", 32'(bus.fault_code), 32'd3);
      pulse_reset();
      bus.opcode = 7'b0000011;
      bus.key_ok = 1'b1;
      cyc("mid fetch", 3'd0, 11'b11000000000, 1'b1);
      cyc("mid decode", 3'd1, 11'b00000000000, 1'b0);
      cyc("mid exec", 3'd2, 11'b00100000000, 1'b0);
      cyc("mid check", 3'd3, 11'b00000000000, 1'b0);
      cyc("mid mem", 3'd4, 11'b00010000000, 1'b0);
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      chk("mid reset state", 32'(bus.state), 32'd0);
      chk("mid reset strobes", 32'(sb_obs), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("mid restart", 3'd0, 11'b10000000000, 1'b0);
      cyc("mid restart2", 3'd0, 11'b10000000000, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the secured RISC-V core. It steps each instruction through fetch, decode, execute, key-checked memory access and writeback. It drives the write strobes for the program counter, instruction register and register file, and the request handshake to instruction and data memory. Every data-memory access is gated by the security block's key grant. The sequencer latches a sticky fault on key denial, memory timeout or illegal opcode.

## Interface
- WAIT_MAX, 15: maximum cycles a memory request may wait for `mem_ready` before timeout (1..15).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  bits [6:0] of the latched instruction; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag; sampled in EXECUTE for branches.
- key_ok  in  1  security grant for the current data address; sampled in MEM_CHECK.
- mem_ready  in  1  memory acknowledge for the current request.
- fetch_req  out  1  instruction-memory request.
- ir_we  out  1  instruction-register load strobe.
- alu_en  out  1  ALU operation strobe.
- mem_req  out  1  data-memory request.
- mem_we  out  1  data-memory write qualifier; valid with `mem_req`.
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4.
- pc_we  out  1  PC update strobe.
- branch_taken  out  1  PC takes the immediate target; valid with `pc_we`.
- retired  out  1  one-cycle pulse per completed instruction.
- fault  out  1  sticky fault flag.
- fault_code  out  2  1 = key denied, 2 = timeout, 3 = illegal opcode.
- state  out  3  current state, for debug.

## Operation
- **States:** FETCH(0), DECODE(1), EXECUTE(2), MEM_CHECK(3), MEM(4), WRITEBACK(5), FAULT(6).
- **FETCH:**
  - `fetch_req` = 1 until `mem_ready`.
  - On `mem_ready`: `ir_we` = 1, then go to DECODE.
- **DECODE:** classify `opcode`.
  - Legal classes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC → EXECUTE.
  - Anything else → FAULT, code 3.
- **EXECUTE:** `alu_en` = 1.
  - BRANCH: `pc_we` = 1, `branch_taken` = `alu_zero`, `retired` = 1, → FETCH.
  - LOAD/STORE: → MEM_CHECK.
  - All others: → WRITEBACK.
- **MEM_CHECK:** no strobes asserted.
  - `key_ok` = 1 → MEM.
  - `key_ok` = 0 → FAULT, code 1. `mem_req` is never raised on a denied access.
- **MEM:** `mem_req` = 1; `mem_we` = 1 for STORE.
  - On `mem_ready`, LOAD → WRITEBACK.
  - On `mem_ready`, STORE: `pc_we` = 1, `retired` = 1, → FETCH.
- **WRITEBACK:** `reg_we` = 1, `pc_we` = 1, `retired` = 1, → FETCH.
  - `wb_sel`: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - `branch_taken` = 1 for JAL/JALR.
- **Timeout:**
  - A 4-bit wait counter clears on entry to FETCH or MEM.
  - It increments each cycle the request is high and `mem_ready` = 0.
  - When it reaches WAIT_MAX without `mem_ready` → FAULT, code 2.
  - If `mem_ready` arrives in the same cycle the counter reaches WAIT_MAX, `mem_ready` wins.
- **FAULT:** absorbing; all strobes are 0. `fault` = 1 and `fault_code` holds until `reset`.
- The opcode class is registered in DECODE. Later states use the registered class, not live `opcode`.

## Timing
- **Reset:**
  - `reset` high at an edge forces state = FETCH, `fault` = 0, `fault_code` = 0, wait counter = 0, opcode class = 0.
  - All outputs are 0 during reset, except `state` = 0.
  - Reset mid-instruction abandons it; no strobe fires in the reset cycle.
- `fetch_req` is high in the first cycle after reset deasserts.
- **Strobe decoding:** strobes decode combinationally from the registered state, registered class, `mem_ready` and `alu_zero`. There is no combinational path from `opcode` to any output.
- **Latency** (zero-wait `mem_ready`, i.e. ready in the first request cycle):
  - BRANCH: 3 cycles.
  - R / I / LUI / AUIPC / JAL / JALR: 4 cycles.
  - STORE: 5 cycles.
  - LOAD: 6 cycles.
  - Each wait cycle adds 1.
- `retired` and `pc_we` coincide exactly once per instruction.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - state encoding;
  - `wb_sel` encodings;
  - fault codes.
- One sub-module, `opcode_classifier`: combinational; maps 7-bit opcode to a class code plus an illegal flag.

## Test plan
- **R-type 0110011**, `mem_ready` = 1 in the first FETCH cycle:
  - states 0→1→2→5→0;
  - `reg_we` = 1 and `wb_sel` = 0 in cycle 4;
  - `retired` pulses once.
- **LOAD 0000011**, `key_ok` = 1, `mem_ready` delayed 3 cycles in MEM:
  - `mem_req` high 4 cycles with `mem_we` = 0;
  - WRITEBACK with `wb_sel` = 1;
  - 9 cycles total.
- **STORE 0100011**, `key_ok` = 0:
  - MEM_CHECK → FAULT with `fault_code` = 1;
  - `mem_req` never asserted;
  - state held at 6 for 20 cycles.
- **BRANCH 1100011:**
  - `alu_zero` = 1 → `pc_we` = 1 and `branch_taken` = 1 in cycle 3;
  - repeat with `alu_zero` = 0 → `branch_taken` = 0.
- **FETCH timeout**, WAIT_MAX = 15, `mem_ready` held 0:
  - FAULT with `fault_code` = 2 after 15 request cycles;
  - variant with `mem_ready` = 1 exactly at count 15 → DECODE, no fault.
- **Illegal opcode and reset:**
  - opcode 1111111 → FAULT, `fault_code` = 3;
  - `reset` pulse → FETCH with `fault` = 0;
  - reset asserted mid-MEM → no `pc_we`/`retired`, restart in FETCH.
